alu_regfile: RTL and testbench
==============================

Name: alu_regfile

Overview:
- Operand source and result sink for the ALU datapath. It supplies rs1/rs2 to the ALU units (alu_or and siblings) and accepts the ALU rd result as writeback.
- Contains a 32-entry register file, write-to-read bypass and a per-register busy scoreboard.
- The scoreboard stalls issue on RAW/WAW hazards against results still in flight.
- x0 is hardwired to zero.

Parameters:
DATA_W, 32, register and operand width
ADDR_W, 5, register address width; NREG = 2**ADDR_W entries

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
rs1_addr  in  ADDR_W  source register 1 index
rs2_addr  in  ADDR_W  source register 2 index
rs1  out  DATA_W  operand 1 to ALU
rs2  out  DATA_W  operand 2 to ALU
iss_valid  in  1  instruction issue request using rs1_addr/rs2_addr, writing iss_rd_addr
iss_rd_addr  in  ADDR_W  destination of issuing instruction
stall  out  1  issue refused this cycle
wb_valid  in  1  ALU result writeback strobe
wb_addr  in  ADDR_W  writeback destination
rd  in  DATA_W  ALU result data
busy  out  NREG  scoreboard bits, bit i = register i has result pending
err  out  1  sticky protocol error

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers = 0, busy = 0, err = 0.
  - stall = 0 and rs1/rs2 = 0 follow combinationally.
  - Reset mid-operation discards all pending busy bits; writebacks arriving after release are treated as unexpected (see err).
- Reads are combinational, zero latency:
  - rsN = 0 if rsN_addr == 0.
  - Else rd if wb_valid && wb_addr == rsN_addr (bypass).
  - Else reg[rsN_addr].
- Write: at posedge, if wb_valid && wb_addr != 0, then reg[wb_addr] <= rd. Writes to x0 are ignored and busy[0] is never set.
- Hazard per source N, combinational:
  - hazN = busy[rsN_addr] && !(wb_valid && wb_addr == rsN_addr); rsN_addr == 0 never hazards.
  - WAW: hazW = busy[iss_rd_addr] && !(wb_valid && wb_addr == iss_rd_addr); iss_rd_addr == 0 never hazards.
  - stall = iss_valid && (haz1 || haz2 || hazW). stall = 0 whenever iss_valid = 0.
- Issue accepted = iss_valid && !stall:
  - at posedge, busy[iss_rd_addr] <= 1 if iss_rd_addr != 0.
  - Stalled issues change no state; the issuer holds its inputs and retries.
- Writeback: at posedge, busy[wb_addr] <= 0.
- Same-cycle accepted issue and writeback to the same address: the set wins, so busy stays 1 (new result outstanding). The register data still takes rd.
- Different addresses: set and clear both apply independently.
- err:
  - set at posedge when wb_valid && wb_addr != 0 && busy[wb_addr] == 0 (writeback with no outstanding issue).
  - The data is still written.
  - err stays 1 until reset.
- Widths: no arithmetic. Addresses are used as full ADDR_W indices, with no wrap beyond NREG-1.

Test Plan:
- Reset then read all 32 addresses -> rs1 = rs2 = 0, busy = 0, stall = 0, err = 0. Assert rst_n low mid-run after writes -> all of these return to 0 immediately, without waiting for clk.
- Issue rd=5 (iss_valid=1, accepted), next cycle wb_valid=1, wb_addr=5, rd=32'hFFFFFFFF:
  - busy[5] = 1 for one cycle, then 0.
  - With rs1_addr=5 during the wb cycle, rs1 = 32'hFFFFFFFF via bypass, and after the edge via the register.
- Issue rd=7, then issue with rs2_addr=7 and no writeback -> stall = 1 held for 3 cycles with no busy change. Assert wb to 7 in cycle 4 -> stall = 0 that same cycle and the issue is accepted.
- Issue rd=3 and writeback wb_addr=3 in the same cycle, with 3 previously busy -> busy[3] remains 1 and reg[3] = rd.
- Writeback wb_addr=0 with rd=32'h12345678 -> rs1 for rs1_addr=0 reads 0, and err stays 0.
- Writeback wb_addr=9 with busy[9]=0 -> reg[9] written and err = 1 from the next edge, remaining 1 until rst_n goes low.

Source files
------------

// File: rtl/alu_regfile.sv
// alu_regfile: 32-entry register file with write-to-read bypass and busy scoreboard stalling RAW/WAW hazards.
module alu_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     rs1_addr,
  input  logic [ADDR_W-1:0]     rs2_addr,
  output logic [DATA_W-1:0]     rs1,
  output logic [DATA_W-1:0]     rs2,
  input  logic                  iss_valid,
  input  logic [ADDR_W-1:0]     iss_rd_addr,
  output logic                  stall,
  input  logic                  wb_valid,
  input  logic [ADDR_W-1:0]     wb_addr,
  input  logic [DATA_W-1:0]     rd,
  output logic [2**ADDR_W-1:0]  busy,
  output logic                  err
);
  localparam int NREG = 2**ADDR_W;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   busy_q, busy_d;
  logic              err_q, err_d;
  logic              wb_hit1, wb_hit2, wb_hitw, haz1, haz2, hazw, iss_ok, wb_live;
  always_comb begin
    wb_live = wb_valid && wb_addr != '0;
    wb_hit1 = wb_valid && wb_addr == rs1_addr;
    wb_hit2 = wb_valid && wb_addr == rs2_addr;
    wb_hitw = wb_valid && wb_addr == iss_rd_addr;
    rs1     = rs1_addr == '0 ? '0 : wb_hit1 ? rd : regs_q[rs1_addr];
    rs2     = rs2_addr == '0 ? '0 : wb_hit2 ? rd : regs_q[rs2_addr];
    haz1    = rs1_addr != '0 && busy_q[rs1_addr] && !wb_hit1;
    haz2    = rs2_addr != '0 && busy_q[rs2_addr] && !wb_hit2;
    hazw    = iss_rd_addr != '0 && busy_q[iss_rd_addr] && !wb_hitw;
    stall   = iss_valid && (haz1 || haz2 || hazw);
    iss_ok  = iss_valid && !stall;
    regs_d  = regs_q;
    if (wb_live) regs_d[wb_addr] = rd;
    busy_d  = busy_q;
    if (wb_valid) busy_d[wb_addr] = 1'b0;
    // set after clear so a same-cycle reissue keeps the new result outstanding
    if (iss_ok && iss_rd_addr != '0) busy_d[iss_rd_addr] = 1'b1;
    busy_d[0] = 1'b0;
    err_d   = err_q || (wb_live && !busy_q[wb_addr]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end
  assign busy = busy_q;
  assign err  = err_q;
endmodule

// File: tb/tb_alu_regfile.sv
// tb_alu_regfile: directed scoreboard bench for alu_regfile.
module tb_alu_regfile;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, iss_rd_addr, wb_addr;
  logic [31:0] rs1, rs2, rd, busy;
  logic        iss_valid, wb_valid, stall, err;
  typedef struct { string tag; logic [31:0] v; } sb_t;
  sb_t sb [$];
  int checks = 0;
  int errors = 0;
  alu_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1(rs1), .rs2(rs2), .iss_valid(iss_valid), .iss_rd_addr(iss_rd_addr),
    .stall(stall), .wb_valid(wb_valid), .wb_addr(wb_addr), .rd(rd),
    .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  task automatic push(input string tag, input logic [31:0] v);
    sb_t e;
    e.tag = tag;
    e.v = v;
    sb.push_back(e);
  endtask
  task automatic pop_chk(input logic [31:0] obs);
    sb_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0; iss_valid = 1'b0; wb_valid = 1'b0;
    rs1_addr = '0; rs2_addr = '0; iss_rd_addr = '0; wb_addr = '0; rd = '0;
    #2;
    push("rst_busy", 0); push("rst_stall", 0); push("rst_err", 0);
    #1;
    pop_chk(busy); pop_chk({31'b0, stall}); pop_chk({31'b0, err});
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
      push("init_rs1", 0); push("init_rs2", 0);
      #1;
      pop_chk(rs1); pop_chk(rs2);
    end
    rs1_addr = '0; rs2_addr = '0;
    // issue x5, then write it back with bypass visible in the wb cycle
    tick();
    iss_valid = 1'b1; iss_rd_addr = 5'd5;
    push("iss5_stall", 0);
    #1; pop_chk({31'b0, stall});
    tick();
    iss_valid = 1'b0; wb_valid = 1'b1; wb_addr = 5'd5; rd = 32'hFFFF_FFFF; rs1_addr = 5'd5;
    push("iss5_busy", 32'h20); push("byp5_rs1", 32'hFFFF_FFFF);
    #1; pop_chk(busy); pop_chk(rs1);
    tick();
    wb_valid = 1'b0; rd = '0;
    push("wb5_busy", 0); push("reg5_rs1", 32'hFFFF_FFFF); push("wb5_err", 0);
    #1; pop_chk(busy); pop_chk(rs1); pop_chk({31'b0, err});
    // RAW stall on x7 held three cycles, released by writeback in the fourth
    iss_valid = 1'b1; iss_rd_addr = 5'd7; rs1_addr = '0;
    tick();
    iss_rd_addr = 5'd10; rs2_addr = 5'd7;
    for (int c = 0; c < 3; c++) begin
      push("raw7_stall", 1); push("raw7_busy", 32'h80);
      #1; pop_chk({31'b0, stall}); pop_chk(busy);
      tick();
    end
    wb_valid = 1'b1; wb_addr = 5'd7; rd = 32'h0000_A5A5;
    push("raw7_release", 0); push("raw7_byp", 32'h0000_A5A5);
    #1; pop_chk({31'b0, stall}); pop_chk(rs2);
    tick();
    iss_valid = 1'b0; wb_valid = 1'b0; rs2_addr = '0;
    push("raw7_busy_after", 32'h400);
    #1; pop_chk(busy);
    // x3 busy, then same-cycle reissue and writeback keeps busy[3]
    iss_valid = 1'b1; iss_rd_addr = 5'd3;
    tick();
    wb_valid = 1'b1; wb_addr = 5'd3; rd = 32'h3333_3333;
    push("same3_stall", 0);
    #1; pop_chk({31'b0, stall});
    tick();
    iss_valid = 1'b0; wb_valid = 1'b0; rs1_addr = 5'd3;
    push("same3_busy", 32'h408); push("same3_reg", 32'h3333_3333); push("same3_err", 0);
    #1; pop_chk(busy); pop_chk(rs1); pop_chk({31'b0, err});
    wb_valid = 1'b1; wb_addr = 5'd3; rd = 32'h3333_0000;
    tick();
    wb_addr = 5'd10; rd = 32'h1010_1010;
    tick();
    wb_valid = 1'b0;
    push("drain_busy", 0); push("drain_err", 0);
    #1; pop_chk(busy); pop_chk({31'b0, err});
    // writes to x0 are dropped and never flag err
    wb_valid = 1'b1; wb_addr = 5'd0; rd = 32'h1234_5678; rs1_addr = 5'd0;
    push("x0_byp", 0);
    #1; pop_chk(rs1);
    tick();
    wb_valid = 1'b0;
    push("x0_rs1", 0); push("x0_err", 0); push("x0_busy", 0);
    #1; pop_chk(rs1); pop_chk({31'b0, err}); pop_chk(busy);
    // unexpected writeback to idle x9 still writes and sets sticky err
    wb_valid = 1'b1; wb_addr = 5'd9; rd = 32'h0000_0099; rs1_addr = 5'd9;
    push("wb9_err_pre", 0);
    #1; pop_chk({31'b0, err});
    tick();
    wb_valid = 1'b0;
    push("wb9_err", 1); push("wb9_reg", 32'h0000_0099);
    #1; pop_chk({31'b0, err}); pop_chk(rs1);
    iss_valid = 1'b1; iss_rd_addr = 5'd12;
    tick();
    rs2_addr = 5'd12; iss_rd_addr = 5'd13;
    push("pre_rst_err", 1); push("pre_rst_busy", 32'h1000); push("pre_rst_stall", 1);
    #1; pop_chk({31'b0, err}); pop_chk(busy); pop_chk({31'b0, stall});
    // asynchronous reset mid-cycle clears everything without a clock edge
    #1; rst_n = 1'b0;
    push("arst_err", 0); push("arst_busy", 0); push("arst_stall", 0); push("arst_rs1", 0);
    #1; pop_chk({31'b0, err}); pop_chk(busy); pop_chk({31'b0, stall}); pop_chk(rs1);
    @(negedge clk); rst_n = 1'b1; iss_valid = 1'b0;
    wb_valid = 1'b1; wb_addr = 5'd12; rd = 32'h0000_0C0C; rs1_addr = 5'd12;
    tick();
    wb_valid = 1'b0;
    push("post_rst_wb_err", 1); push("post_rst_reg12", 32'h0000_0C0C); push("post_rst_busy", 0);
    #1; pop_chk({31'b0, err}); pop_chk(rs1); pop_chk(busy);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
